video_timing_ctrl: RTL and testbench
====================================

Name: video_timing_ctrl

Overview:
- Timing sequencer for the TMDS output path. Generates the horizontal and vertical counters, hsync, vsync and active-video enable that drive the three channel encoders.
- ve_out feeds each encoder's video-enable input. ctrl_out = {vs, hs} feeds the blue channel's control input; red and green control inputs are tied to 0.
- Supports a start/stop handshake: streaming always stops on a frame boundary, so the encoders never see a truncated frame.

Parameters:
- ACTIVE_H, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- ACTIVE_V, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- FC_W, 6, frame counter width

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  asynchronous, active-high reset
- run_in  in  1  level; 1 = generate frames, 0 = stop at the next end of frame
- hcount_out  out  11  current pixel index, 0..H_TOTAL-1
- vcount_out  out  10  current line index, 0..V_TOTAL-1
- hs_out  out  1  hsync, polarity set by HS_POL
- vs_out  out  1  vsync, polarity set by VS_POL
- ve_out  out  1  active video enable
- ctrl_out  out  2  {vs_out, hs_out}, for the blue encoder control input
- nf_out  out  1  one-cycle new-frame pulse
- fc_out  out  FC_W  frame count
- busy_out  out  1  high whenever the state is not IDLE

Behaviour:
- Derived constants:
  - H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP
  - V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP
  - With defaults: 1650 x 750.
- Reset (asynchronous, any time, including mid-frame): state goes to IDLE and outputs take these values:
  - hcount_out = 0, vcount_out = 0
  - hs_out = ~HS_POL, vs_out = ~VS_POL
  - ve_out = 0, ctrl_out follows hs_out/vs_out
  - nf_out = 0, fc_out = 0, busy_out = 0
- All outputs are flops. Outputs in a given cycle are mutually consistent: each decode corresponds to the hcount/vcount shown in that same cycle.
- State machine has three states: IDLE, RUN, DRAIN.
  - IDLE:
    - Counters are held at 0 and all outputs keep their reset values.
    - If run_in=1 at a clock edge: go to RUN. From that same edge, outputs show (h=0, v=0) with ve_out=1 and busy_out=1.
  - RUN:
    - Counters advance every cycle. hcount wraps from H_TOTAL-1 to 0 and increments vcount; vcount wraps from V_TOTAL-1 to 0.
    - If run_in=0: go to DRAIN, with counting unchanged.
  - DRAIN:
    - Counting continues normally.
    - If run_in returns to 1 before the frame ends: go back to RUN with no discontinuity.
    - When the edge that would wrap (H_TOTAL-1, V_TOTAL-1) to (0,0) occurs: go to IDLE instead and outputs take their reset values.
    - run_in is sampled only at cycles, not buffered, so a toggle inside a frame has no effect beyond the frame boundary.
- Decode rules (state RUN or DRAIN):
  - ve_out = 1 iff hcount < ACTIVE_H and vcount < ACTIVE_V.
  - hs_out = HS_POL iff ACTIVE_H+H_FP <= hcount < ACTIVE_H+H_FP+H_SYNC. This applies on every line, including vertical blanking.
  - vs_out = VS_POL iff ACTIVE_V+V_FP <= vcount < ACTIVE_V+V_FP+V_SYNC, for the whole line, independent of hcount.
  - nf_out = 1 for exactly one cycle, when hcount == ACTIVE_H and vcount == ACTIVE_V (start of vertical blanking).
  - fc_out increments modulo 2^FC_W in the same cycle that nf_out is high.
- Boundary conditions:
  - A DRAIN that starts after the nf cycle of a frame still completes that frame; no extra nf pulse is generated.
  - fc_out is not cleared on stop. Only reset clears it.
  - Counter arithmetic uses full port width; no overflow beyond H_TOTAL/V_TOTAL.
  - Parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024. Any H_FP, H_SYNC, H_BP, V_FP, V_SYNC or V_BP equal to 0 is illegal; an elaboration-time assertion rejects it.

Test Plan:
Bench parameters: ACTIVE_H=8, H_FP=2, H_SYNC=2, H_BP=2, ACTIVE_V=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=VS_POL=1, FC_W=3. This gives H_TOTAL=14, V_TOTAL=7, 98 cycles per frame.
- Reset then run_in held at 1:
  - First cycle after the edge: h=0, v=0, ve=1, busy=1.
  - ve is high on h 0..7 of lines 0..3 only.
  - hs is high at h=10,11 on every line.
  - vs is high for all of v=5.
- Frame pulse and counter:
  - nf is high at (h=8, v=4) only, once per 98 cycles.
  - fc reads 1, 2, … and wraps 7 -> 0 on the 8th pulse.
- Graceful stop: drop run_in at (h=3, v=2):
  - Counting continues to (13,6).
  - The next edge gives IDLE: h=0, v=0, ve=0, hs=0, vs=0, busy=0.
  - fc retains its value.
- Drain cancel: drop run_in at (3,2), raise it again at (5,5):
  - No stop occurs; the wrap to (0,0) is seamless and busy stays 1.
- Mid-frame async reset: assert rst_in at (9,1), between clock edges:
  - All outputs go to reset values immediately, fc=0.
  - After release with run_in=1, generation restarts at (0,0).
- Polarity: HS_POL=VS_POL=0:
  - hs and vs idle high and pulse low at the same positions as above.
  - ctrl_out equals {vs_out, hs_out} in every cycle.

Source files
------------

// File: rtl/video_timing_ctrl.sv
// Video timing sequencer for the TMDS output path: raster counters, sync/enable decodes,
// new-frame pulse and frame counter, with a start/stop handshake that stops only at frame end.
module video_timing_ctrl #(
  parameter int unsigned ACTIVE_H = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned ACTIVE_V = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned FC_W     = 6
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            run_in,
  output logic [10:0]     hcount_out,
  output logic [9:0]      vcount_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            ve_out,
  output logic [1:0]      ctrl_out,
  output logic            nf_out,
  output logic [FC_W-1:0] fc_out,
  output logic            busy_out
);

  localparam int unsigned H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP;

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
  begin : gen_bad_porch
    $fatal(1, "video_timing_ctrl: porch and sync widths must be non-zero");
  end
  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : gen_bad_total
    $fatal(1, "video_timing_ctrl: raster exceeds counter width");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(ACTIVE_H);
  localparam logic [10:0] HS_START = 11'(ACTIVE_H + H_FP);
  localparam logic [10:0] HS_END   = 11'(ACTIVE_H + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(ACTIVE_V);
  localparam logic [9:0]  VS_START = 10'(ACTIVE_V + V_FP);
  localparam logic [9:0]  VS_END   = 10'(ACTIVE_V + V_FP + V_SYNC);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [10:0]     hcnt_q, hcnt_d, hcnt_nxt;
  logic [9:0]      vcnt_q, vcnt_d, vcnt_nxt;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            ve_q, ve_d;
  logic            nf_q, nf_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            busy_q;
  logic            active;
  logic            frame_end;

  // Raster position one pixel on from the current one.
  always_comb begin
    hcnt_nxt = hcnt_q + 11'd1;
    vcnt_nxt = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_nxt = '0;
      vcnt_nxt = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    end
  end

  assign frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

  always_comb begin
    state_d = state_q;
    hcnt_d  = '0;
    vcnt_d  = '0;
    active  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_in) begin
          state_d = StRun;
          active  = 1'b1;
        end
      end
      StRun: begin
        active = 1'b1;
        hcnt_d = hcnt_nxt;
        vcnt_d = vcnt_nxt;
        if (!run_in) state_d = StDrain;
      end
      StDrain: begin
        if (run_in) begin
          state_d = StRun;
          active  = 1'b1;
          hcnt_d  = hcnt_nxt;
          vcnt_d  = vcnt_nxt;
        end else if (frame_end) begin
          state_d = StIdle;
        end else begin
          active = 1'b1;
          hcnt_d = hcnt_nxt;
          vcnt_d = vcnt_nxt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decodes are taken from the next position so every registered output matches its counters.
  always_comb begin
    ve_d = active && (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
    hs_d = (active && (hcnt_d >= HS_START) && (hcnt_d < HS_END)) ? HS_POL : ~HS_POL;
    vs_d = (active && (vcnt_d >= VS_START) && (vcnt_d < VS_END)) ? VS_POL : ~VS_POL;
    nf_d = active && (hcnt_d == H_ACT) && (vcnt_d == V_ACT);
    fc_d = nf_d ? fc_q + FC_W'(1) : fc_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      ve_q    <= 1'b0;
      nf_q    <= 1'b0;
      fc_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ve_q    <= ve_d;
      nf_q    <= nf_d;
      fc_q    <= fc_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign hcount_out = hcnt_q;
  assign vcount_out = vcnt_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ve_out     = ve_q;
  assign ctrl_out   = {vs_q, hs_q};
  assign nf_out     = nf_q;
  assign fc_out     = fc_q;
  assign busy_out   = busy_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: a linear frame-position model drives expectations for a
// positive-polarity and a negative-polarity instance sharing the same stimulus.
module tb_video_timing_ctrl;

  localparam int AH = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int AV = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int FCW = 3;
  localparam int H_TOT = AH + HFP + HSW + HBP;
  localparam int V_TOT = AV + VFP + VSW + VBP;
  localparam int F_TOT = H_TOT * V_TOT;
  localparam int NF_POS = AV * H_TOT + AH;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic run_in = 1'b0;

  logic [10:0]    hc_p, hc_n;
  logic [9:0]     vc_p, vc_n;
  logic           hs_p, vs_p, ve_p, nf_p, busy_p;
  logic           hs_n, vs_n, ve_n, nf_n, busy_n;
  logic [1:0]     ctrl_p, ctrl_n;
  logic [FCW-1:0] fc_p, fc_n;

  video_timing_ctrl #(
    .ACTIVE_H(AH), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .ACTIVE_V(AV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .FC_W(FCW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .run_in(run_in),
    .hcount_out(hc_p), .vcount_out(vc_p), .hs_out(hs_p), .vs_out(vs_p), .ve_out(ve_p),
    .ctrl_out(ctrl_p), .nf_out(nf_p), .fc_out(fc_p), .busy_out(busy_p)
  );

  video_timing_ctrl #(
    .ACTIVE_H(AH), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .ACTIVE_V(AV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .FC_W(FCW)
  ) dut_n (
    .clk_in(clk_in), .rst_in(rst_in), .run_in(run_in),
    .hcount_out(hc_n), .vcount_out(vc_n), .hs_out(hs_n), .vs_out(vs_n), .ve_out(ve_n),
    .ctrl_out(ctrl_n), .nf_out(nf_n), .fc_out(fc_n), .busy_out(busy_n)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Model: streaming flag, pending-stop flag, linear position within the frame, frame count.
  bit m_act = 1'b0;
  bit m_pend = 1'b0;
  int m_pos = 0;
  int m_fc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h (model pos %0d act %0b)",
               tag, $time, got, exp, m_pos, m_act);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_pend = 1'b0; m_pos = 0; m_fc = 0;
  endtask

  task automatic model_step(input bit run);
    if (!m_act) begin
      if (run) begin m_act = 1'b1; m_pend = 1'b0; m_pos = 0; end
    end else if (run) begin
      m_pend = 1'b0; m_pos = (m_pos + 1) % F_TOT;
    end else if (m_pend && m_pos == F_TOT - 1) begin
      m_act = 1'b0; m_pend = 1'b0; m_pos = 0;
    end else begin
      m_pend = 1'b1; m_pos = (m_pos + 1) % F_TOT;
    end
    if (m_act && m_pos == NF_POS) m_fc = (m_fc + 1) % (1 << FCW);
  endtask

  task automatic check_all();
    int h, v;
    bit e_ve, e_hs, e_vs, e_nf;
    h = m_act ? m_pos % H_TOT : 0;
    v = m_act ? m_pos / H_TOT : 0;
    e_ve = m_act && h < AH && v < AV;
    e_hs = m_act && h >= AH + HFP && h < AH + HFP + HSW;
    e_vs = m_act && v >= AV + VFP && v < AV + VFP + VSW;
    e_nf = m_act && m_pos == NF_POS;
    chk("hcount", 32'(hc_p), 32'(h));
    chk("vcount", 32'(vc_p), 32'(v));
    chk("ve", 32'(ve_p), 32'(e_ve));
    chk("hs", 32'(hs_p), 32'(e_hs));
    chk("vs", 32'(vs_p), 32'(e_vs));
    chk("ctrl", 32'(ctrl_p), 32'({e_vs, e_hs}));
    chk("nf", 32'(nf_p), 32'(e_nf));
    chk("fc", 32'(fc_p), 32'(m_fc));
    chk("busy", 32'(busy_p), 32'(m_act));
    chk("hcount_n", 32'(hc_n), 32'(h));
    chk("hs_n", 32'(hs_n), 32'(!e_hs));
    chk("vs_n", 32'(vs_n), 32'(!e_vs));
    chk("ctrl_n", 32'(ctrl_n), 32'({!e_vs, !e_hs}));
    chk("ve_n", 32'(ve_n), 32'(e_ve));
    chk("fc_n", 32'(fc_n), 32'(m_fc));
  endtask

  // Drive run for the next edge, step the model at that edge, check on the falling edge.
  task automatic cycle(input bit run);
    run_in = run;
    @(posedge clk_in);
    model_step(run);
    @(negedge clk_in);
    check_all();
  endtask

  task automatic run_to(input bit run, input int target, input int budget);
    int n = 0;
    while (!(m_act && m_pos == target) && n < budget) begin
      cycle(run);
      n++;
    end
  endtask

  // Reset asserted between edges: outputs must clear without a clock.
  task automatic async_reset(input bit run_after);
    #2 rst_in = 1'b1;
    #1 model_reset();
    check_all();
    run_in = run_after;
    @(posedge clk_in);
    @(negedge clk_in);
    check_all();
    rst_in = 1'b0;
  endtask

  initial begin
    bit run_v;
    int r;
    model_reset();
    repeat (2) @(negedge clk_in);
    check_all();
    rst_in = 1'b0;
    repeat (3) cycle(1'b0);

    // Continuous streaming through more than eight frames for the fc wrap.
    for (int i = 0; i < 9 * F_TOT + 5; i++) cycle(1'b1);

    // Graceful stop dropped at (3,2), then idle for a while.
    run_to(1'b1, 2 * H_TOT + 3, 2 * F_TOT);
    for (int i = 0; i < F_TOT; i++) cycle(1'b0);
    repeat (5) cycle(1'b0);

    // Drain cancelled at (5,5): the frame wrap must be seamless.
    run_to(1'b1, 2 * H_TOT + 3, 2 * F_TOT);
    run_to(1'b0, 5 * H_TOT + 5, 2 * F_TOT);
    for (int i = 0; i < F_TOT + 10; i++) cycle(1'b1);

    // Mid-frame asynchronous reset at (9,1).
    run_to(1'b1, 1 * H_TOT + 9, 2 * F_TOT);
    async_reset(1'b1);
    for (int i = 0; i < F_TOT + 3; i++) cycle(1'b1);

    // Randomised run level with long stop intervals and occasional resets.
    run_v = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (run_v && r < 30) run_v = 1'b0;
      else if (!run_v && r < 10) run_v = 1'b1;
      if (r == 999) async_reset(run_v);
      cycle(run_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
